bicubic_col_accum: RTL and testbench
====================================

BICUBIC_COL_ACCUM -- requirements
Module: bicubic_col_accum

Interface
REQ-001 SHALL have parameter INTER_PRODUCT_WIDTH, default 24, meaning the signed width of each incoming horizontal inner product.
REQ-002 SHALL have parameter ACC_WIDTH, default 36, meaning the signed vertical accumulator width.
REQ-003 SHALL have parameter FRAC_BITS, default 14, meaning the total fixed-point fraction bits of the accumulated value (7 horizontal + 7 vertical).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 SHALL have port s_valid, input, 1 bit: the row product is valid.
REQ-007 SHALL have port s_ready, output, 1 bit: the block accepts a row product.
REQ-008 SHALL have port s_row_sum, input, INTER_PRODUCT_WIDTH bits: the signed horizontal inner product of one window row.
REQ-009 SHALL have port s_vweight, input, 3 bits: the vertical weight code for that row.
REQ-010 SHALL have port m_valid, output, 1 bit: the output pixel is valid.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts the pixel.
REQ-012 SHALL have port m_pixel, output, 8 bits: the unsigned interpolated pixel.

Function
REQ-013 SHALL transfer an input beat only on a cycle where s_valid && s_ready, and an output beat only on a cycle where m_valid && m_ready.
REQ-014 SHALL implement a three-state FSM: ACCUM -> NORM -> OUT -> ACCUM.
REQ-015 SHALL assert s_ready only in ACCUM, and m_valid only in OUT.
REQ-016 SHALL, in ACCUM, keep a 2-bit row counter and, on each input beat, do acc <= (cnt==0 ? 0 : acc) + sext(s_row_sum) * COEF[s_vweight], then increment cnt.
REQ-017 SHALL, on the beat with cnt==3, wrap cnt to 0 and go to NORM on the next cycle.
REQ-018 SHALL, in NORM, compute r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift) and saturate it: r<0 -> 0, r>255 -> 255, else r[7:0].
REQ-019 SHALL register the NORM result into m_pixel and enter OUT on the following cycle.
REQ-020 SHALL have a latency of 2 cycles from the fourth input beat's edge to m_valid high.
REQ-021 SHALL hold m_pixel stable while m_valid && !m_ready, for any duration of backpressure.
REQ-022 SHALL, in OUT, return to ACCUM on the next cycle once m_ready is high; no input is accepted in the OUT cycle itself.
REQ-023 SHALL give a minimum period of 6 cycles per pixel.
REQ-024 SHALL ignore s_row_sum and s_vweight when s_valid is low; gaps between row beats are allowed, and acc and cnt hold during them.
REQ-025 SHALL not overflow the accumulator: 24-bit x 9-bit signed over 4 terms fits 35 bits, below ACC_WIDTH.

Reset
REQ-026 SHALL, on rst high at a clock edge, set state=ACCUM, cnt=0, acc=0, m_pixel=0, m_valid=0, s_ready=1 on the next cycle.
REQ-027 SHALL, on reset mid-operation (any state, including OUT with data pending), discard partial accumulations and pending pixels without emitting them.
REQ-028 SHALL give rst priority over any simultaneous handshake in the same cycle.

Structure
REQ-029 SHALL take from the shared package bicubic_pkg: the localparam table COEF[0..7] (signed 9-bit) = {0, +128, +72, +32, +104, +16, -8, -12}, FRAC_BITS, and the FSM state enum.
REQ-030 SHALL place rounding and saturation in one combinational sub-module, bicubic_round_clamp (ACC_WIDTH in, 8 bits out), for reuse by the horizontal path.
REQ-031 SHALL have every output driven from flops.

Verification
REQ-032 SHALL cover nominal: four beats of s_row_sum=12800 with code 3 (+32) -> acc=1638400, m_pixel=100, m_valid high exactly 2 cycles after the fourth beat.
REQ-033 SHALL cover saturation: beats {40000, 0, 0, 0} with codes {1,0,0,0} -> r=313 -> m_pixel=255; beats {-5000, 0, 0, 0} with code 1 -> m_pixel=0.
REQ-034 SHALL cover rounding: one beat 12864 with code 1, others with code 0 -> acc=1646592 -> r=100.5 rounds to m_pixel=101; 12863 -> m_pixel=100.
REQ-035 SHALL cover backpressure: m_ready low for 10 cycles during OUT -> m_pixel constant, s_ready low throughout; m_ready high -> s_ready high next cycle.
REQ-036 SHALL cover reset mid-frame: rst pulsed after beat 2 -> no m_valid is produced; the next four beats of 12800 with code 3 yield m_pixel=100.
REQ-037 SHALL cover bubbles: s_valid toggling 0/1 between beats -> the same result as back-to-back beats, with cnt advancing only on handshakes.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic interpolation datapath: vertical weight table,
// fixed-point fraction width and the column-accumulator FSM states.
package bicubic_pkg;

  localparam int FRAC_BITS = 14;

  // Vertical weight codes, Q1.7 signed: 0, +1.0, +0.5625, +0.25, +0.8125, +0.125, -0.0625, -0.09375
  localparam logic signed [8:0] COEF [0:7] = '{
    9'sd0, 9'sd128, 9'sd72, 9'sd32, 9'sd104, 9'sd16, -9'sd8, -9'sd12
  };

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_NORM  = 2'd1,
    ST_OUT   = 2'd2
  } col_state_e;

endpackage

// File: rtl/bicubic_round_clamp.sv
// Round-half-up of a signed fixed-point accumulator to an integer, clamped to 0..255.
// Purely combinational so the horizontal path can reuse it.
module bicubic_round_clamp #(
  parameter int ACC_WIDTH = 36,
  parameter int FRAC_BITS = 14
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic        [7:0]           pixel_o
);

  localparam logic signed [ACC_WIDTH-1:0] RND_BIAS = ACC_WIDTH'(1) << (FRAC_BITS - 1);

  logic signed [ACC_WIDTH-1:0] rounded;
  logic signed [ACC_WIDTH-1:0] shifted;

  assign rounded = acc_i + RND_BIAS;
  assign shifted = rounded >>> FRAC_BITS;

  always_comb begin
    pixel_o = shifted[7:0];
    if (shifted[ACC_WIDTH-1]) begin
      pixel_o = 8'd0;
    end else if (|shifted[ACC_WIDTH-2:8]) begin
      pixel_o = 8'd255;
    end
  end

endmodule

// File: rtl/bicubic_col_accum.sv
// Vertical pass of the bicubic filter: weights four row products, sums them, then
// rounds/clamps to an 8-bit pixel held under valid/ready backpressure.
module bicubic_col_accum #(
  parameter int INTER_PRODUCT_WIDTH = 24,
  parameter int ACC_WIDTH           = 36,
  parameter int FRAC_BITS           = bicubic_pkg::FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [INTER_PRODUCT_WIDTH-1:0] s_row_sum,
  input  logic [2:0]                     s_vweight,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [7:0]                     m_pixel
);

  import bicubic_pkg::*;

  col_state_e                  state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [7:0]                  pix_q, pix_d;
  logic                        m_valid_q, m_valid_d;
  logic                        s_ready_q, s_ready_d;

  logic signed [ACC_WIDTH-1:0] row_ext;
  logic signed [ACC_WIDTH-1:0] coef_ext;
  logic signed [ACC_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic [7:0]                  norm_pix;
  logic                        in_fire;
  logic                        out_fire;

  assign row_ext  = {{(ACC_WIDTH-INTER_PRODUCT_WIDTH){s_row_sum[INTER_PRODUCT_WIDTH-1]}}, s_row_sum};
  assign coef_ext = {{(ACC_WIDTH-9){COEF[s_vweight][8]}}, COEF[s_vweight]};
  assign prod     = row_ext * coef_ext;
  // The first row of a window starts a fresh sum, so no separate clear cycle is needed.
  assign acc_base = (cnt_q == 2'd0) ? '0 : acc_q;

  assign in_fire  = s_valid && s_ready_q;
  assign out_fire = m_valid_q && m_ready;

  bicubic_round_clamp #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_clamp (
    .acc_i   (acc_q),
    .pixel_o (norm_pix)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    pix_d     = pix_q;
    m_valid_d = m_valid_q;
    s_ready_d = s_ready_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_fire) begin
          acc_d = acc_base + prod;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d   = ST_NORM;
            s_ready_d = 1'b0;
          end
        end
      end
      ST_NORM: begin
        pix_d     = norm_pix;
        m_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (out_fire) begin
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = ST_ACCUM;
        end
      end
      default: begin
        state_d   = ST_ACCUM;
        cnt_d     = 2'd0;
        m_valid_d = 1'b0;
        s_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      cnt_q     <= 2'd0;
      acc_q     <= '0;
      pix_q     <= 8'd0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      pix_q     <= pix_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_pixel = pix_q;

endmodule

// File: tb/tb_bicubic_col_accum.sv
// Directed and randomized checks of bicubic_col_accum against an arithmetic reference model.
module tb_bicubic_col_accum;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_row_sum;
  logic [2:0]  s_vweight;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_pixel;

  int checks = 0;
  int errors = 0;

  localparam int COEF_T [0:7] = '{0, 128, 72, 32, 104, 16, -8, -12};

  bicubic_col_accum #(
    .INTER_PRODUCT_WIDTH (24),
    .ACC_WIDTH           (36),
    .FRAC_BITS           (14)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_row_sum (s_row_sum),
    .s_vweight (s_vweight),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_pixel   (m_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_pix(input int rows[4], input int codes[4]);
    longint acc;
    longint r;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += longint'(rows[i]) * longint'(COEF_T[codes[i]]);
    r = (acc + 64'sd8192) >>> 14;
    if (r < 0) return 0;
    if (r > 255) return 255;
    return int'(r);
  endfunction

  task automatic send_beat(input int row, input int code, input bit bubbles);
    int guard;
    if (bubbles) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        s_valid   = 1'b0;
        s_row_sum = 24'($urandom);
        s_vweight = 3'($urandom);
        step();
      end
    end
    s_valid   = 1'b1;
    s_row_sum = row[23:0];
    s_vweight = code[2:0];
    guard = 0;
    while (!s_ready && guard < 50) begin
      step();
      guard++;
    end
    check("beat_accept_wait", {31'd0, s_ready}, 32'd1);
    step();
    s_valid   = 1'b0;
    s_row_sum = 24'($urandom);
    s_vweight = 3'($urandom);
  endtask

  // Call right after the fourth beat's edge: checks latency, value, hold and release.
  task automatic collect_pixel(input int exp, input int stall, input string tag);
    check({tag, "_norm_no_valid"}, {31'd0, m_valid}, 32'd0);
    step();
    check({tag, "_valid_lat2"}, {31'd0, m_valid}, 32'd1);
    check({tag, "_pixel"}, {24'd0, m_pixel}, exp);
    check({tag, "_out_no_ready"}, {31'd0, s_ready}, 32'd0);
    for (int k = 0; k < stall; k++) begin
      step();
      check({tag, "_hold"}, {22'd0, m_valid, s_ready, m_pixel}, {22'd0, 1'b1, 1'b0, 8'(exp)});
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check({tag, "_release_s_ready"}, {30'd0, s_ready, m_valid}, 32'd2);
  endtask

  task automatic do_pixel(input int rows[4], input int codes[4], input bit bubbles,
                          input int stall, input int exp_in, input string tag);
    int exp;
    exp = (exp_in >= 0) ? exp_in : model_pix(rows, codes);
    for (int i = 0; i < 4; i++) send_beat(rows[i], codes[i], bubbles);
    collect_pixel(exp, stall, tag);
  endtask

  task automatic no_valid_window(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      if (m_valid) seen++;
      step();
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int rows[4];
    int codes[4];
    int nom_rows[4];
    int nom_codes[4];
    nom_rows  = '{12800, 12800, 12800, 12800};
    nom_codes = '{3, 3, 3, 3};

    rst = 1'b1; s_valid = 1'b0; s_row_sum = '0; s_vweight = '0; m_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_s_ready", {31'd0, s_ready}, 32'd1);
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_m_pixel", {24'd0, m_pixel}, 32'd0);

    do_pixel(nom_rows, nom_codes, 1'b0, 0, 100, "nominal");
    codes = '{1, 0, 0, 0};
    rows = '{40000, 0, 0, 0};  do_pixel(rows, codes, 1'b0, 0, 255, "sat_high");
    rows = '{-5000, 0, 0, 0};  do_pixel(rows, codes, 1'b0, 0, 0,   "sat_low");
    rows = '{12864, 0, 0, 0};  do_pixel(rows, codes, 1'b0, 0, 101, "round_up");
    rows = '{12863, 0, 0, 0};  do_pixel(rows, codes, 1'b0, 0, 100, "round_down");
    do_pixel(nom_rows, nom_codes, 1'b0, 10, 100, "backpressure");
    do_pixel(nom_rows, nom_codes, 1'b1, 2, 100, "bubbles_nom");
    rows = '{12864, 0, 0, 0};  do_pixel(rows, codes, 1'b1, 0, 101, "bubbles_round");

    // Reset after two beats, colliding with a third beat's handshake.
    send_beat(12800, 3, 1'b0);
    send_beat(12800, 3, 1'b0);
    s_valid = 1'b1; s_row_sum = 24'd12800; s_vweight = 3'd3; rst = 1'b1;
    step();
    rst = 1'b0; s_valid = 1'b0;
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_s_ready", {31'd0, s_ready}, 32'd1);
    no_valid_window(8, "midrst_no_pixel");
    do_pixel(nom_rows, nom_codes, 1'b0, 0, 100, "after_midrst");

    // Reset while a pixel waits in OUT.
    for (int i = 0; i < 4; i++) send_beat(40000, 1, 1'b0);
    step();
    check("outrst_pending", {31'd0, m_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("outrst_state", {22'd0, m_valid, s_ready, m_pixel}, {22'd0, 1'b0, 1'b1, 8'd0});
    no_valid_window(8, "outrst_no_pixel");
    do_pixel(nom_rows, nom_codes, 1'b0, 0, 100, "after_outrst");

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) rows[i] = int'($urandom) >>> 8;
        else rows[i] = int'($urandom_range(0, 60000)) - 10000;
        codes[i] = int'($urandom_range(0, 7));
      end
      do_pixel(rows, codes, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
